rx_pause_decoder: RTL and testbench
===================================

Name: rx_pause_decoder

Overview:
- Receive-side decoder for IEEE 802.3x MAC control PAUSE frames. It is the counterpart of the transmit-side pause generator in the tri-speed MAC core.
- Sits on the receive byte stream between the receive function and the receive host FIFO.
- Parses each frame header, validates DA/type/opcode, and qualifies the frame with the end-of-frame CRC status.
- Loads a pause-quanta countdown that stalls the local transmitter. Also flags control frames so the FIFO can drop them.

Parameters:
- ACCEPT_UNICAST, 1, 1 = also accept a PAUSE frame addressed to station_addr; 0 = multicast 01-80-C2-00-00-01 only.
- QUANTA_TICKS, 64, byte-enable ticks per pause quantum (512 bit times / 8).

Ports:
- clk  in  1  receive clock
- reset  in  1  asynchronous active-high reset
- byte_en  in  1  byte-time clock enable; 1 every clk at 1G, divided down at 10/100
- rx_data  in  8  received byte, DA first
- rx_dv  in  1  rx_data valid; sampled only when byte_en=1
- rx_sof  in  1  coincident with the first DA byte
- rx_eof  in  1  coincident with the last byte (FCS included)
- rx_crc_ok  in  1  valid with rx_eof; 1 = FCS good
- station_addr  in  48  local MAC address; byte 0 = addr[47:40]
- pause_en  in  1  receive flow-control enable
- ctrl_frame  out  1  high from header byte 13 to the end of a frame with type 0x8808
- pause_rx  out  1  one-clk pulse on acceptance of a valid PAUSE frame
- pause_quanta  out  16  last accepted quanta value
- pause_active  out  1  transmitter hold request
- pause_timer  out  16  remaining quanta

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and the byte counter and prescaler are 0.
- Every parse action is qualified by byte_en & rx_dv. A byte counter `idx` (5 bits) counts header bytes and saturates at 18.
- FSM states:
  - IDLE: rx_sof → PARSE with idx=1, checking byte 0.
  - PARSE: compare each byte by index.
    - Bytes 0-5: DA matches multicast (flag m_ok) or station_addr (flag u_ok, only when ACCEPT_UNICAST=1).
    - Bytes 12-13: type must be 0x88, 0x08. ctrl_frame asserts in the clk after byte 13 matches.
    - Bytes 14-15: opcode must be 0x00, 0x01.
    - Bytes 16-17: quanta is captured MSB first into a shadow register.
    - Any mismatch → DISCARD.
    - idx reaching 18 → WAIT_EOF.
  - WAIT_EOF: on rx_eof, accept only when rx_crc_ok=1 and pause_en=1. Accept means: pause_rx pulse, pause_quanta ← shadow, pause_timer ← shadow, prescaler ← 0. Then → IDLE.
  - DISCARD: on rx_eof → IDLE, with no timer action.
- ctrl_frame clears in the clk after rx_eof.
- Boundary cases:
  - rx_eof in PARSE (frame shorter than 18 bytes) → IDLE, no accept.
  - rx_sof in any non-IDLE state: restart the parse on that byte, drop the partial frame, clear ctrl_frame.
  - Frame with type 0x8808 but an opcode other than 0x0001: ctrl_frame=1, no accept.
- Timer:
  - When pause_timer≠0, the prescaler increments on byte_en. When the prescaler reaches QUANTA_TICKS-1 it wraps to 0 and pause_timer decrements.
  - pause_active = (pause_timer≠0), registered along with the timer.
  - Accepted quanta=0 clears the timer, and pause_active drops on the next clk.
  - A new accept while counting overwrites the timer and restarts the prescaler; it does not add to the old value.
  - An accept and a decrement in the same clk: the load wins.
  - pause_en low does not clear a running timer; it only blocks new loads.
- Latency: pause_rx and the timer load happen 1 clk after the rx_eof sample; pause_active asserts 1 clk after that.
- Asynchronous reset mid-frame or mid-pause clears everything immediately. The next frame is parsed only from a fresh rx_sof.

Test Plan:
- Byte_en=1 every clk. Multicast PAUSE, quanta 0x0003, crc_ok=1, pause_en=1 → pause_rx pulse and pause_quanta=0x0003. pause_active held for exactly 192 clks, with the timer stepping 3→2→1→0.
- Same frame with crc_ok=0 → no pause_rx. ctrl_frame still asserts from byte 13 to eof. Timer stays 0.
- ACCEPT_UNICAST=1, station_addr=00-11-22-33-44-55, DA matching, quanta 0x0010 → accepted. Same frame with ACCEPT_UNICAST=0 → rejected.
- While the timer=5 is mid-count, accept quanta 0x0000 → pause_active low 2 clks after eof. Separately, accept 0x0002 → timer=2 with the prescaler restarted.
- Opcode 0x0002 frame; a frame truncated at byte 15 with rx_eof; and an rx_sof at byte 10 followed by a valid PAUSE → only the final frame is accepted, quanta correct.
- byte_en at 1/10 duty, quanta 1 → pause_active lasts 640 clks. Async reset asserted at clk 100 → all outputs 0 immediately.

Source files
------------

// File: rtl/rx_pause_decoder_if.sv
// rtl/rx_pause_decoder_if.sv - receive byte stream into the PAUSE decoder
// One byte per byte_en tick, framed by rx_sof/rx_eof with end-of-frame FCS status.
interface rx_pause_decoder_if;
  logic       byte_en;
  logic [7:0] rx_data;
  logic       rx_dv;
  logic       rx_sof;
  logic       rx_eof;
  logic       rx_crc_ok;

  modport master (
    output byte_en,
    output rx_data,
    output rx_dv,
    output rx_sof,
    output rx_eof,
    output rx_crc_ok
  );

  modport slave (
    input byte_en,
    input rx_data,
    input rx_dv,
    input rx_sof,
    input rx_eof,
    input rx_crc_ok
  );
endinterface

// File: rtl/rx_pause_decoder.sv
// rtl/rx_pause_decoder.sv - 802.3x PAUSE frame parser and pause-quanta countdown
// Flags MAC control frames for the host FIFO and holds the local transmitter while paused.
module rx_pause_decoder #(
  parameter int ACCEPT_UNICAST = 1,
  parameter int QUANTA_TICKS   = 64
) (
  input  logic                clk,
  input  logic                reset,
  rx_pause_decoder_if.slave   rx,
  input  logic [47:0]         station_addr,
  input  logic                pause_en,
  output logic                ctrl_frame,
  output logic                pause_rx,
  output logic [15:0]         pause_quanta,
  output logic                pause_active,
  output logic [15:0]         pause_timer
);

  localparam int              PW       = (QUANTA_TICKS > 1) ? $clog2(QUANTA_TICKS) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(QUANTA_TICKS - 1);
  localparam logic [47:0]     PAUSE_MC = 48'h0180_C200_0001;
  localparam logic [4:0]      IDX_MAX  = 5'd18;

  typedef enum logic [1:0] {IDLE, PARSE, WAIT_EOF, DISCARD} state_t;

  state_t        state;
  logic [4:0]    idx;
  logic [4:0]    pos;
  logic          m_ok;
  logic          u_ok;
  logic [15:0]   shadow;
  logic [PW-1:0] prescaler;

  logic          fire;
  logic          restart;
  logic [7:0]    mc_exp;
  logic [7:0]    uc_exp;
  logic          mc_hit;
  logic          uc_hit;
  logic          da_hit;
  logic          accept;

  // A byte carrying rx_sof is always header byte 0, whatever state we are in.
  always_comb begin
    fire    = rx.byte_en & rx.rx_dv;
    restart = fire & rx.rx_sof;
    pos     = rx.rx_sof ? 5'd0 : idx;
    mc_exp  = 8'h00;
    uc_exp  = 8'h00;
    case (pos)
      5'd0: begin mc_exp = PAUSE_MC[47:40]; uc_exp = station_addr[47:40]; end
      5'd1: begin mc_exp = PAUSE_MC[39:32]; uc_exp = station_addr[39:32]; end
      5'd2: begin mc_exp = PAUSE_MC[31:24]; uc_exp = station_addr[31:24]; end
      5'd3: begin mc_exp = PAUSE_MC[23:16]; uc_exp = station_addr[23:16]; end
      5'd4: begin mc_exp = PAUSE_MC[15:8];  uc_exp = station_addr[15:8];  end
      5'd5: begin mc_exp = PAUSE_MC[7:0];   uc_exp = station_addr[7:0];   end
      default: ;
    endcase
    mc_hit = (rx.rx_sof | m_ok) && (rx.rx_data == mc_exp);
    uc_hit = (ACCEPT_UNICAST != 0) && (rx.rx_sof | u_ok) && (rx.rx_data == uc_exp);
    da_hit = mc_hit | uc_hit;
    accept = fire & ~rx.rx_sof & rx.rx_eof & (state == WAIT_EOF) & rx.rx_crc_ok & pause_en;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= 5'd0;
      m_ok         <= 1'b0;
      u_ok         <= 1'b0;
      shadow       <= 16'h0000;
      ctrl_frame   <= 1'b0;
      pause_rx     <= 1'b0;
      pause_quanta <= 16'h0000;
    end else begin
      pause_rx <= accept;
      if (accept) begin
        pause_quanta <= shadow;
      end
      if (restart) begin
        idx        <= 5'd1;
        m_ok       <= mc_hit;
        u_ok       <= uc_hit;
        ctrl_frame <= 1'b0;
        state      <= da_hit ? PARSE : DISCARD;
      end else if (fire) begin
        case (state)
          PARSE: begin
            if (rx.rx_eof) begin
              // Runt frame: ended before the quanta field was complete.
              state      <= IDLE;
              idx        <= 5'd0;
              m_ok       <= 1'b0;
              u_ok       <= 1'b0;
              ctrl_frame <= 1'b0;
            end else begin
              idx <= idx + 5'd1;
              case (idx)
                5'd1, 5'd2, 5'd3, 5'd4, 5'd5: begin
                  m_ok <= mc_hit;
                  u_ok <= uc_hit;
                  if (!da_hit) state <= DISCARD;
                end
                5'd12: if (rx.rx_data != 8'h88) state <= DISCARD;
                5'd13: begin
                  if (rx.rx_data != 8'h08) state <= DISCARD;
                  else ctrl_frame <= 1'b1;
                end
                5'd14: if (rx.rx_data != 8'h00) state <= DISCARD;
                5'd15: if (rx.rx_data != 8'h01) state <= DISCARD;
                5'd16: shadow[15:8] <= rx.rx_data;
                5'd17: begin
                  shadow[7:0] <= rx.rx_data;
                  state       <= WAIT_EOF;
                end
                default: ;
              endcase
            end
          end
          WAIT_EOF, DISCARD: begin
            if (rx.rx_eof) begin
              state      <= IDLE;
              idx        <= 5'd0;
              m_ok       <= 1'b0;
              u_ok       <= 1'b0;
              ctrl_frame <= 1'b0;
            end else if (idx != IDX_MAX) begin
              idx <= idx + 5'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A fresh accept always overwrites the count and restarts the quantum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pause_timer  <= 16'h0000;
      prescaler    <= '0;
      pause_active <= 1'b0;
    end else begin
      pause_active <= (pause_timer != 16'h0000);
      if (accept) begin
        pause_timer <= shadow;
        prescaler   <= '0;
      end else if ((pause_timer != 16'h0000) && rx.byte_en) begin
        if (prescaler == PRE_LAST) begin
          prescaler   <= '0;
          pause_timer <= pause_timer - 16'h0001;
        end else begin
          prescaler <= prescaler + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_pause_decoder.sv
// tb/tb_rx_pause_decoder.sv - directed bench for rx_pause_decoder
// Two instances share one stream: unicast acceptance enabled and disabled.
module tb_rx_pause_decoder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rx_pause_decoder_if rxif ();
  logic [47:0] station_addr;
  logic        pause_en;

  logic        ctrl_u, prx_u, act_u;
  logic [15:0] pq_u, tmr_u;
  logic        ctrl_m, prx_m, act_m;
  logic [15:0] pq_m, tmr_m;

  rx_pause_decoder #(.ACCEPT_UNICAST(1), .QUANTA_TICKS(64)) dut_u (
    .clk(clk), .reset(reset), .rx(rxif.slave), .station_addr(station_addr), .pause_en(pause_en),
    .ctrl_frame(ctrl_u), .pause_rx(prx_u), .pause_quanta(pq_u), .pause_active(act_u), .pause_timer(tmr_u)
  );

  rx_pause_decoder #(.ACCEPT_UNICAST(0), .QUANTA_TICKS(64)) dut_m (
    .clk(clk), .reset(reset), .rx(rxif.slave), .station_addr(station_addr), .pause_en(pause_en),
    .ctrl_frame(ctrl_m), .pause_rx(prx_m), .pause_quanta(pq_m), .pause_active(act_m), .pause_timer(tmr_m)
  );

  localparam logic [47:0] MC = 48'h0180_C200_0001;
  localparam logic [47:0] UC = 48'h0011_2233_4455;

  int checks   = 0;
  int failures = 0;
  int be_div   = 1;

  logic [7:0] fb    [0:127];
  bit         fsof  [0:127];
  bit         feof  [0:127];
  logic       chist [0:127];
  int         flen  = 0;

  // byte_en is updated shortly after each rising edge, for the following edge.
  initial begin
    int be_cnt;
    be_cnt = 0;
    rxif.byte_en = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (be_cnt >= be_div - 1) be_cnt = 0;
      else be_cnt = be_cnt + 1;
      rxif.byte_en = (be_cnt == 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_pause(input logic [47:0] da, input logic [15:0] typ, input logic [15:0] op,
                           input logic [15:0] q, input int nbytes, input bit with_eof);
    for (int i = 0; i < nbytes; i++) begin
      logic [7:0] b;
      if (i < 6)        b = da[47-8*i -: 8];
      else if (i < 12)  b = 8'hA0 + 8'(i);
      else if (i == 12) b = typ[15:8];
      else if (i == 13) b = typ[7:0];
      else if (i == 14) b = op[15:8];
      else if (i == 15) b = op[7:0];
      else if (i == 16) b = q[15:8];
      else if (i == 17) b = q[7:0];
      else if (i < 60)  b = 8'h00;
      else              b = 8'hC0 + 8'(i - 60);
      fb[flen]   = b;
      fsof[flen] = (i == 0);
      feof[flen] = with_eof && (i == nbytes - 1);
      flen++;
    end
  endtask

  task automatic wait_be();
    @(negedge clk);
    while (!rxif.byte_en) @(negedge clk);
  endtask

  task automatic idle_bus();
    rxif.rx_data   = 8'h00;
    rxif.rx_dv     = 1'b0;
    rxif.rx_sof    = 1'b0;
    rxif.rx_eof    = 1'b0;
    rxif.rx_crc_ok = 1'b0;
  endtask

  // Returns on the falling edge right after the rx_eof byte was sampled.
  task automatic send(input bit crc);
    for (int i = 0; i < flen; i++) begin
      wait_be();
      chist[i]       = ctrl_u;
      rxif.rx_data   = fb[i];
      rxif.rx_dv     = 1'b1;
      rxif.rx_sof    = fsof[i];
      rxif.rx_eof    = feof[i];
      rxif.rx_crc_ok = feof[i] ? crc : 1'b0;
    end
    @(negedge clk);
    idle_bus();
    flen = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    int k;
    int prev;
    int tseq[$];

    reset        = 1'b1;
    station_addr = UC;
    pause_en     = 1'b1;
    idle_bus();
    repeat (3) @(negedge clk);
    chk("rst_ctrl", ctrl_u, 0);
    chk("rst_pause_rx", prx_u, 0);
    chk("rst_quanta", pq_u, 0);
    chk("rst_active", act_u, 0);
    chk("rst_timer", tmr_u, 0);
    chk("rst_timer_m", tmr_m, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Multicast PAUSE, quanta 3
    add_pause(MC, 16'h8808, 16'h0001, 16'h0003, 64, 1'b1);
    send(1'b1);
    chk("mc_pause_rx", prx_u, 1);
    chk("mc_quanta", pq_u, 16'h0003);
    chk("mc_timer_load", tmr_u, 16'h0003);
    chk("mc_active_lag", act_u, 0);
    chk("mc_quanta_m", pq_m, 16'h0003);
    chk("mc_ctrl_b12", chist[13], 0);
    chk("mc_ctrl_b13", chist[14], 1);
    chk("mc_ctrl_end", ctrl_u, 0);
    cnt  = 0;
    prev = 3;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (32'(tmr_u) != prev) begin
        tseq.push_back(int'(tmr_u));
        prev = int'(tmr_u);
      end
      if (k == 0) chk("mc_pulse_width", prx_u, 0);
      if (act_u) cnt++;
      else if (cnt > 0) break;
    end
    chk("mc_active_clks", cnt, 192);
    chk("mc_tseq_len", tseq.size(), 3);
    if (tseq.size() == 3) begin
      chk("mc_tseq0", tseq[0], 2);
      chk("mc_tseq1", tseq[1], 1);
      chk("mc_tseq2", tseq[2], 0);
    end

    // Same frame with bad FCS
    add_pause(MC, 16'h8808, 16'h0001, 16'h0003, 64, 1'b1);
    send(1'b0);
    chk("crc_pause_rx", prx_u, 0);
    chk("crc_ctrl_b13", chist[14], 1);
    chk("crc_ctrl_last", chist[63], 1);
    chk("crc_ctrl_end", ctrl_u, 0);
    chk("crc_timer", tmr_u, 0);

    // Unicast to station address
    add_pause(UC, 16'h8808, 16'h0001, 16'h0010, 64, 1'b1);
    send(1'b1);
    chk("uc_pause_rx", prx_u, 1);
    chk("uc_quanta", pq_u, 16'h0010);
    chk("uc_rej_pause_rx", prx_m, 0);
    chk("uc_rej_quanta", pq_m, 16'h0003);

    // Zero quanta while counting
    add_pause(MC, 16'h8808, 16'h0001, 16'h0005, 64, 1'b1);
    send(1'b1);
    repeat (30) @(negedge clk);
    add_pause(MC, 16'h8808, 16'h0001, 16'h0000, 64, 1'b1);
    send(1'b1);
    chk("zero_pause_rx", prx_u, 1);
    chk("zero_timer", tmr_u, 0);
    chk("zero_active_e0", act_u, 1);
    @(negedge clk);
    chk("zero_active_e1", act_u, 0);

    // Reload overwrites and restarts the prescaler
    add_pause(MC, 16'h8808, 16'h0001, 16'h0005, 64, 1'b1);
    send(1'b1);
    repeat (30) @(negedge clk);
    add_pause(MC, 16'h8808, 16'h0001, 16'h0002, 64, 1'b1);
    send(1'b1);
    chk("reload_timer", tmr_u, 16'h0002);
    k = 0;
    while (tmr_u == 16'h0002 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reload_first_step", k, 64);
    chk("reload_timer_after", tmr_u, 16'h0001);
    k = 0;
    while (act_u && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("reload_expired", act_u, 0);

    // Opcode 0x0002
    add_pause(MC, 16'h8808, 16'h0002, 16'h0009, 64, 1'b1);
    send(1'b1);
    chk("op2_pause_rx", prx_u, 0);
    chk("op2_ctrl_b13", chist[14], 1);
    chk("op2_ctrl_last", chist[63], 1);
    chk("op2_ctrl_end", ctrl_u, 0);
    chk("op2_timer", tmr_u, 0);

    // Truncated after byte 15
    add_pause(MC, 16'h8808, 16'h0001, 16'h0009, 16, 1'b1);
    send(1'b1);
    chk("trunc_pause_rx", prx_u, 0);
    chk("trunc_ctrl_b13", chist[14], 1);
    chk("trunc_ctrl_end", ctrl_u, 0);
    chk("trunc_timer", tmr_u, 0);

    // rx_sof at byte 10 restarts onto a valid frame
    add_pause(MC, 16'h8808, 16'h0001, 16'h0777, 10, 1'b0);
    add_pause(MC, 16'h8808, 16'h0001, 16'h0042, 64, 1'b1);
    send(1'b1);
    chk("restart_pause_rx", prx_u, 1);
    chk("restart_quanta", pq_u, 16'h0042);
    chk("restart_timer", tmr_u, 16'h0042);
    chk("restart_ctrl_b13", chist[24], 1);

    // pause_en low blocks the load but leaves the running count alone
    pause_en = 1'b0;
    add_pause(MC, 16'h8808, 16'h0001, 16'h0007, 64, 1'b1);
    send(1'b1);
    chk("pen_pause_rx", prx_u, 0);
    chk("pen_timer", tmr_u, 16'h0041);
    chk("pen_active", act_u, 1);
    pause_en = 1'b1;

    // byte_en at 1/10, quanta 1
    pulse_reset();
    be_div = 10;
    add_pause(MC, 16'h8808, 16'h0001, 16'h0001, 64, 1'b1);
    send(1'b1);
    chk("slow_pause_rx", prx_u, 1);
    cnt = 0;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (act_u) cnt++;
      else if (cnt > 0) break;
    end
    chk("slow_active_clks", cnt, 640);

    // Asynchronous reset mid-pause
    add_pause(MC, 16'h8808, 16'h0001, 16'h0005, 64, 1'b1);
    send(1'b1);
    repeat (100) @(negedge clk);
    chk("pre_reset_active", act_u, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ctrl", ctrl_u, 0);
    chk("arst_pause_rx", prx_u, 0);
    chk("arst_quanta", pq_u, 0);
    chk("arst_active", act_u, 0);
    chk("arst_timer", tmr_u, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
